// File: rtl/expr_eval_ctrl.sv
// rtl/expr_eval_ctrl.sv - streaming checker/evaluator for "d(op d)*=" expressions
// Precedence is handled by keeping completed additive terms in sum and the live product in term.
module expr_eval_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [7:0]   in_char,
    output logic         in_ready,
    output logic         res_valid,
    output logic         res_ok,
    output logic [W-1:0] res_value,
    input  logic         res_ready
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_OPND = 3'd1;
    localparam logic [2:0] ST_OPER = 3'd2;
    localparam logic [2:0] ST_ERR  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [W-1:0] sum_q, sum_d;
    logic [W-1:0] term_q, term_d;
    logic         mul_pend_q, mul_pend_d;
    logic         res_valid_q, res_valid_d;
    logic         res_ok_q, res_ok_d;
    logic [W-1:0] res_value_q, res_value_d;

    logic         accept;
    logic         is_dig, is_plus, is_star, is_eq;
    logic [W-1:0] dig_w;
    logic [W-1:0] prod;

    assign accept  = in_valid && !res_valid_q;
    assign is_dig  = (in_char >= 8'h30) && (in_char <= 8'h39);
    assign is_plus = (in_char == 8'h2B);
    assign is_star = (in_char == 8'h2A);
    assign is_eq   = (in_char == 8'h3D);
    assign dig_w   = {{(W-4){1'b0}}, in_char[3:0]};
    assign prod    = term_q * dig_w;

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        term_d      = term_q;
        mul_pend_d  = mul_pend_q;
        res_valid_d = res_valid_q;
        res_ok_d    = res_ok_q;
        res_value_d = res_value_q;

        if (state_q == ST_DONE) begin
            if (res_ready) begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
                res_ok_d    = 1'b0;
                res_value_d = '0;
                sum_d       = '0;
                term_d      = '0;
                mul_pend_d  = 1'b0;
            end
        end else if (accept) begin
            // Any EQ not handled as a success below ends the expression with ok=0.
            if (is_eq) begin
                state_d     = ST_DONE;
                res_valid_d = 1'b1;
                res_ok_d    = 1'b0;
                res_value_d = '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (is_dig) begin
                        state_d    = ST_OPND;
                        term_d     = dig_w;
                        sum_d      = '0;
                        mul_pend_d = 1'b0;
                    end else if (!is_eq) begin
                        state_d = ST_ERR;
                    end
                end
                ST_OPND: begin
                    if (is_plus) begin
                        state_d    = ST_OPER;
                        sum_d      = sum_q + term_q;
                        mul_pend_d = 1'b0;
                    end else if (is_star) begin
                        state_d    = ST_OPER;
                        mul_pend_d = 1'b1;
                    end else if (is_eq) begin
                        res_ok_d    = 1'b1;
                        res_value_d = sum_q + term_q;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                ST_OPER: begin
                    if (is_dig) begin
                        state_d = ST_OPND;
                        term_d  = mul_pend_q ? prod : dig_w;
                    end else if (!is_eq) begin
                        state_d = ST_ERR;
                    end
                end
                ST_ERR: begin
                end
                default: begin
                    state_d = ST_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            term_q      <= '0;
            mul_pend_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_ok_q    <= 1'b0;
            res_value_q <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            term_q      <= term_d;
            mul_pend_q  <= mul_pend_d;
            res_valid_q <= res_valid_d;
            res_ok_q    <= res_ok_d;
            res_value_q <= res_value_d;
        end
    end

    assign in_ready  = !res_valid_q;
    assign res_valid = res_valid_q;
    assign res_ok    = res_ok_q;
    assign res_value = res_value_q;

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// tb/tb_expr_eval_ctrl.sv - scoreboard bench for expr_eval_ctrl
module tb_expr_eval_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = 8'h00;
    logic        in_ready;
    logic        res_valid;
    logic        res_ok;
    logic [15:0] res_value;
    logic        res_ready = 1'b1;

    int tests = 0;
    int fails = 0;
    logic [16:0] sb[$];
    bit seen = 1'b0;
    bit done = 1'b0;

    expr_eval_ctrl #(.W(16)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .res_valid(res_valid), .res_ok(res_ok),
        .res_value(res_value), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result on each rising res_valid.
    initial begin
        forever begin
            @(negedge clk);
            if (done) break;
            if (res_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    logic [16:0] e;
                    e = sb.pop_front();
                    chk("res_ok", {31'd0, res_ok}, {31'd0, e[16]});
                    chk("res_value", {16'd0, res_value}, {16'd0, e[15:0]});
                end
            end
            if (res_valid !== 1'b1) seen = 1'b0;
        end
    end

    task automatic drive_chars(input string s);
        for (int i = 0; i < s.len(); i++) begin
            in_valid = 1'b1;
            in_char  = s[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Sends a full expression; with res_ready high the result is released on the next edge.
    task automatic send_expr(input string s, input bit ok, input logic [15:0] val);
        sb.push_back({ok, val});
        drive_chars(s);
        chk({"latency_", s}, {31'd0, res_valid}, 1);
        if (res_ready) begin
            @(posedge clk); #1;
            chk({"release_", s}, {31'd0, res_valid}, 0);
        end
    endtask

    initial begin
        #2;
        chk("rst_valid", {31'd0, res_valid}, 0);
        chk("rst_ok", {31'd0, res_ok}, 0);
        chk("rst_value", {16'd0, res_value}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;

        send_expr("3+4*2=", 1'b1, 16'd11);
        send_expr("2*3+4*5=", 1'b1, 16'd26);
        send_expr("9*9*9*9*9*9=", 1'b1, 16'd7153);
        send_expr("3++4=", 1'b0, 16'd0);
        send_expr("5=", 1'b1, 16'd5);
        send_expr("3a4=", 1'b0, 16'd0);
        send_expr("=", 1'b0, 16'd0);
        send_expr("12=", 1'b0, 16'd0);
        send_expr("7+=", 1'b0, 16'd0);
        send_expr("*3=", 1'b0, 16'd0);
        send_expr("0=", 1'b1, 16'd0);

        res_ready = 1'b0;
        send_expr("8*8=", 1'b1, 16'd64);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_char  = (i % 2 == 0) ? 8'h31 : 8'h3D;
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, res_valid}, 1);
            chk("bp_value", {16'd0, res_value}, 64);
            chk("bp_in_ready", {31'd0, in_ready}, 0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {31'd0, res_valid}, 0);
        send_expr("1=", 1'b1, 16'd1);

        drive_chars("7*");
        clr = 1'b1;
        #1;
        chk("clr_valid", {31'd0, res_valid}, 0);
        chk("clr_ok", {31'd0, res_ok}, 0);
        chk("clr_value", {16'd0, res_value}, 0);
        chk("clr_in_ready", {31'd0, in_ready}, 1);
        clr = 1'b0;
        @(posedge clk); #1;
        send_expr("2=", 1'b1, 16'd2);

        res_ready = 1'b0;
        send_expr("4=", 1'b1, 16'd4);
        @(negedge clk); #1;
        clr = 1'b1;
        #1;
        chk("clr_done_valid", {31'd0, res_valid}, 0);
        chk("clr_done_in_ready", {31'd0, in_ready}, 1);
        clr = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        send_expr("6*7=", 1'b1, 16'd42);

        repeat (3) @(posedge clk);
        #1;
        done = 1'b1;
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
